// File: rtl/race_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : race_sequencer_if
// Brief    : Bundle of game-level control inputs and race status outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface race_sequencer_if;
  logic       game_visible;
  logic       vblnk;
  logic       lap_finished;
  logic       checkpoints_passed;
  logic       max_time_exceeded;
  logic [1:0] race_state;
  logic [1:0] countdown_digit;
  logic       car_enable;
  logic       timer_run;
  logic       timer_clear;
  logic [3:0] lap_count;
  logic       race_done;
  logic       dnf;

  // Sequencer side
  modport slave (
    input  game_visible, vblnk, lap_finished, checkpoints_passed, max_time_exceeded,
    output race_state, countdown_digit, car_enable, timer_run, timer_clear,
           lap_count, race_done, dnf
  );

  // Environment side (main_fsm, checkpoints, lap_timer, timing chain)
  modport master (
    output game_visible, vblnk, lap_finished, checkpoints_passed, max_time_exceeded,
    input  race_state, countdown_digit, car_enable, timer_run, timer_clear,
           lap_count, race_done, dnf
  );
endinterface
`default_nettype wire

// File: rtl/race_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : race_sequencer
// Brief    : Start countdown, lap counting and race termination sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module race_sequencer #(
  parameter int LAPS           = 3,
  parameter int COUNT_SECONDS  = 3,
  parameter int FRAMES_PER_SEC = 60
) (
  input  wire logic        pclk,
  input  wire logic        rst,
  race_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_RACING    = 2'd2,
    S_FINISHED  = 2'd3
  } state_e;

  localparam logic [7:0] C_FRAME_LAST = 8'(FRAMES_PER_SEC - 1);
  localparam logic [1:0] C_DIGIT_INIT = 2'(COUNT_SECONDS);
  localparam logic [3:0] C_LAPS       = 4'(LAPS);

  state_e     state_q, state_d;
  logic [1:0] digit_q, digit_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [3:0] lap_count_q, lap_count_d;
  logic       car_enable_q, car_enable_d;
  logic       timer_run_q, timer_run_d;
  logic       timer_clear_q, timer_clear_d;
  logic       race_done_q, race_done_d;
  logic       dnf_q, dnf_d;
  logic       vblnk_q, vblnk_d;
  logic       lap_fin_q, lap_fin_d;

  logic       w_tick;
  logic       w_lap_rise;
  logic [3:0] w_lap_next;

  assign w_tick     = bus.vblnk & ~vblnk_q;
  assign w_lap_rise = bus.lap_finished & ~lap_fin_q;
  assign w_lap_next = (lap_count_q == 4'hF) ? 4'hF : lap_count_q + 4'd1;

  always_comb begin
    state_d       = state_q;
    digit_d       = digit_q;
    frame_cnt_d   = frame_cnt_q;
    lap_count_d   = lap_count_q;
    car_enable_d  = car_enable_q;
    timer_run_d   = timer_run_q;
    timer_clear_d = 1'b0;
    race_done_d   = 1'b0;
    dnf_d         = dnf_q;
    vblnk_d       = bus.vblnk;
    lap_fin_d     = bus.lap_finished;

    // Leaving the race screen wins over everything else
    if (!bus.game_visible) begin
      state_d      = S_IDLE;
      digit_d      = 2'd0;
      frame_cnt_d  = 8'd0;
      lap_count_d  = 4'd0;
      car_enable_d = 1'b0;
      timer_run_d  = 1'b0;
      dnf_d        = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d       = S_COUNTDOWN;
          digit_d       = C_DIGIT_INIT;
          frame_cnt_d   = 8'd0;
          lap_count_d   = 4'd0;
          dnf_d         = 1'b0;
          timer_clear_d = 1'b1;
        end
        S_COUNTDOWN: begin
          if (w_tick) begin
            if (frame_cnt_q == C_FRAME_LAST) begin
              frame_cnt_d = 8'd0;
              if (digit_q == 2'd1) begin
                state_d      = S_RACING;
                digit_d      = 2'd0;
                car_enable_d = 1'b1;
                timer_run_d  = 1'b1;
              end else begin
                digit_d = digit_q - 2'd1;
              end
            end else begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
          end
        end
        S_RACING: begin
          // Timeout outranks a lap completing in the same cycle
          if (bus.max_time_exceeded) begin
            state_d      = S_FINISHED;
            dnf_d        = 1'b1;
            race_done_d  = 1'b1;
            car_enable_d = 1'b0;
            timer_run_d  = 1'b0;
          end else if (w_lap_rise && bus.checkpoints_passed) begin
            lap_count_d = w_lap_next;
            if (w_lap_next == C_LAPS) begin
              state_d      = S_FINISHED;
              race_done_d  = 1'b1;
              car_enable_d = 1'b0;
              timer_run_d  = 1'b0;
            end
          end
        end
        S_FINISHED: begin
          car_enable_d = 1'b0;
          timer_run_d  = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      digit_q       <= 2'd0;
      frame_cnt_q   <= 8'd0;
      lap_count_q   <= 4'd0;
      car_enable_q  <= 1'b0;
      timer_run_q   <= 1'b0;
      timer_clear_q <= 1'b0;
      race_done_q   <= 1'b0;
      dnf_q         <= 1'b0;
      vblnk_q       <= 1'b0;
      lap_fin_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      digit_q       <= digit_d;
      frame_cnt_q   <= frame_cnt_d;
      lap_count_q   <= lap_count_d;
      car_enable_q  <= car_enable_d;
      timer_run_q   <= timer_run_d;
      timer_clear_q <= timer_clear_d;
      race_done_q   <= race_done_d;
      dnf_q         <= dnf_d;
      vblnk_q       <= vblnk_d;
      lap_fin_q     <= lap_fin_d;
    end
  end

  assign bus.race_state      = state_q;
  assign bus.countdown_digit = digit_q;
  assign bus.car_enable      = car_enable_q;
  assign bus.timer_run       = timer_run_q;
  assign bus.timer_clear     = timer_clear_q;
  assign bus.lap_count       = lap_count_q;
  assign bus.race_done       = race_done_q;
  assign bus.dnf             = dnf_q;

endmodule
`default_nettype wire

// File: tb/tb_race_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_race_sequencer
// Brief    : Scoreboard bench for race_sequencer against a race-rules model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_race_sequencer;
  localparam int LAPS = 2;
  localparam int CS   = 3;
  localparam int FPS  = 2;

  logic clk;
  logic rst_n;
  race_sequencer_if bus ();

  race_sequencer #(.LAPS(LAPS), .COUNT_SECONDS(CS), .FRAMES_PER_SEC(FPS)) dut (
    .pclk (clk),
    .rst  (rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] exp;
    string       tag;
  } sb_entry_t;

  sb_entry_t sb[$];
  int        n_checks = 0;
  int        n_err    = 0;
  string     cur_tag  = "reset";

  // Race-rules model: phase 0 idle, 1 countdown, 2 racing, 3 finished
  int m_phase, m_cd_ticks, m_laps;
  bit m_dnf, m_clear, m_done, m_prev_vb, m_prev_lap;

  function automatic logic [12:0] model_out();
    logic [1:0] dig;
    bit         run;
    dig = (m_phase == 1) ? 2'(CS - m_cd_ticks / FPS) : 2'd0;
    run = (m_phase == 2);
    return {2'(m_phase), dig, run, run, m_clear, 4'(m_laps), m_done, m_dnf};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cd_ticks = 0; m_laps = 0;
    m_dnf = 0; m_clear = 0; m_done = 0; m_prev_vb = 0; m_prev_lap = 0;
  endtask

  task automatic model_step(input bit gv, vb, lf, cp, mte);
    bit tick, rise;
    tick = vb && !m_prev_vb;
    rise = lf && !m_prev_lap;
    m_prev_vb = vb; m_prev_lap = lf;
    m_clear = 0; m_done = 0;
    if (!gv) begin
      m_phase = 0; m_laps = 0; m_dnf = 0; m_cd_ticks = 0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_cd_ticks = 0; m_laps = 0; m_dnf = 0; m_clear = 1;
    end else if (m_phase == 1) begin
      if (tick) begin
        m_cd_ticks++;
        if (m_cd_ticks == CS * FPS) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      if (mte) begin
        m_phase = 3; m_dnf = 1; m_done = 1;
      end else if (rise && cp) begin
        m_laps = (m_laps >= 15) ? 15 : m_laps + 1;
        if (m_laps == LAPS) begin
          m_phase = 3; m_done = 1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [12:0] act, input logic [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%b required=%b (state,digit,car,run,clear,laps,done,dnf)",
               tag, $time, act, exp);
    end
  endtask

  function automatic logic [12:0] dut_out();
    return {bus.race_state, bus.countdown_digit, bus.car_enable, bus.timer_run,
            bus.timer_clear, bus.lap_count, bus.race_done, bus.dnf};
  endfunction

  task automatic push_exp();
    sb_entry_t e;
    e.exp = model_out();
    e.tag = cur_tag;
    sb.push_back(e);
  endtask

  task automatic drive(input bit gv, vb, lf, cp, mte);
    @(negedge clk);
    rst_n                  = 1'b1;
    bus.game_visible       = gv;
    bus.vblnk              = vb;
    bus.lap_finished       = lf;
    bus.checkpoints_passed = cp;
    bus.max_time_exceeded  = mte;
    model_step(gv, vb, lf, cp, mte);
    push_exp();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check({cur_tag, "_async"}, dut_out(), model_out());
    push_exp();
    @(negedge clk);
    push_exp();
  endtask

  task automatic idle(input int n, input bit gv);
    for (int i = 0; i < n; i++) drive(gv, 0, 0, 0, 0);
  endtask

  task automatic countdown();
    for (int i = 0; i < CS * FPS; i++) begin
      drive(1, 1, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
    end
  endtask

  task automatic restart();
    idle(1, 0);
    drive(1, 0, 0, 0, 0);
  endtask

  // Monitor: pops one expected snapshot per cycle the DUT presents
  initial begin
    sb_entry_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.tag, dut_out(), e.exp);
      end
    end
  end

  initial begin
    rst_n                  = 1'b0;
    bus.game_visible       = 1'b0;
    bus.vblnk              = 1'b0;
    bus.lap_finished       = 1'b0;
    bus.checkpoints_passed = 1'b0;
    bus.max_time_exceeded  = 1'b0;
    model_reset();

    cur_tag = "reset";
    do_reset();
    idle(2, 0);

    cur_tag = "countdown";
    drive(1, 0, 0, 0, 0);
    countdown();
    idle(2, 1);

    cur_tag = "lap_nocp";
    drive(1, 0, 1, 0, 0);
    idle(2, 1);
    cur_tag = "lap_valid";
    drive(1, 0, 1, 1, 0);
    drive(1, 0, 0, 1, 0);
    cur_tag = "lap_final_long";
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 1, 0);
    drive(1, 1, 1, 1, 1);
    idle(3, 1);

    cur_tag = "timeout";
    restart();
    countdown();
    drive(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 1);
    idle(2, 1);

    cur_tag = "collision";
    restart();
    countdown();
    drive(1, 0, 1, 1, 0);
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 1, 1, 1);
    idle(3, 1);

    cur_tag = "abort";
    restart();
    for (int i = 0; i < FPS; i++) begin
      drive(1, 1, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    idle(2, 1);

    cur_tag = "reset_racing";
    restart();
    countdown();
    drive(1, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 0);
    do_reset();
    idle(2, 1);

    cur_tag = "random";
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) do_reset();
      drive($urandom_range(0, 149) != 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 79) == 0);
    end

    @(negedge clk);
    @(posedge clk);
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
